ofmap_drain: RTL and testbench
==============================

// Module: ofmap_drain
// PURPOSE
//  Drains one layer's output feature map (ofmap) from the psum path of the PE array.
//  Per word: optional ReLU, rounding right-shift requantisation, signed saturation.
//  Emits one activation per handshake in raster order (col, row, channel) with a flat index.
//  Its stream is what the bench dumps to the ofmap results file for the line-by-line
//  OUTPUT/EXPECTED compare; word order and count must match that file exactly.
// PARAMETERS
//  PSUM_WIDTH  16  signed psum width from array
//  ACT_WIDTH   16  signed output activation width (<= PSUM_WIDTH)
//  OFMAP_W     55  ofmap columns (AlexNet Conv1)
//  OFMAP_H     55  ofmap rows
//  OFMAP_C     96  ofmap channels
//  SHIFT_W      5  width of cfg_shift
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  async active-low reset
//  start        in   1                  pulse: begin drain of one ofmap
//  cfg_relu_en  in   1                  1 = clamp negatives to 0 before shift
//  cfg_shift    in   SHIFT_W            right-shift amount, sampled at start
//  psum_data    in   PSUM_WIDTH         signed psum from array
//  psum_valid   in   1                  psum_data valid
//  psum_ready   out  1                  drain accepts psum this cycle
//  ofmap_data   out  ACT_WIDTH          requantised activation
//  ofmap_valid  out  1                  ofmap_data valid
//  ofmap_ready  in   1                  consumer accepts
//  ofmap_index  out  32                 flat index c*H*W + r*W + col of ofmap_data
//  ofmap_last   out  1                  final word of the map, qualified by ofmap_valid
//  busy         out  1                  drain in progress
//  done         out  1                  1-cycle pulse after final output handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0; counters, cfg regs cleared.
//  FSM: IDLE -start-> DRAIN -last input accepted-> FLUSH -last output accepted-> DONE -> IDLE.
//   DONE lasts one cycle and drives done=1. busy=1 in DRAIN and FLUSH only.
//   start is ignored outside IDLE. cfg_relu_en/cfg_shift latched at start, held to DONE.
//  Input handshake: psum_ready = (state==DRAIN) && (!ofmap_valid || ofmap_ready).
//   Transfer happens when psum_valid && psum_ready.
//  Output: single registered stage. Accepted psum appears on ofmap_* next cycle (latency 1).
//   ofmap_data/index/last are held stable while ofmap_valid && !ofmap_ready.
//   Valid clears on handshake unless a new psum is accepted the same cycle (full throughput).
//  Counters: col 0..W-1, row 0..H-1, ch 0..C-1, flat idx 0..W*H*C-1. All advance on input
//   transfer; col wraps -> row++, row wraps -> ch++. All counters return to 0 on entering IDLE.
//  Requant (combinational, per accepted psum):
//   x = relu_en && psum<0 ? 0 : psum.
//   y = (x + (shift ? 1<<(shift-1) : 0)) >>> shift. Round half up; arithmetic shift.
//   Sum is computed at PSUM_WIDTH+1 bits so the rounding add cannot overflow.
//   Saturate y to [-(2^(ACT_WIDTH-1)), 2^(ACT_WIDTH-1)-1].
//  ofmap_last=1 when idx==W*H*C-1. Entering FLUSH: psum_ready=0, extra psums not consumed.
//  Reset mid-drain aborts immediately. No partial state survives. Next start restarts at idx 0.
// STRUCTURE
//  shared_pkg: PSUM_WIDTH, ACT_WIDTH, Conv1 OFMAP_W/H/C constants.
//  shared_pkg: typedef enum drain_state_t {IDLE, DRAIN, FLUSH, DONE}.
//  Sub-module ofmap_requant (combinational ReLU/round/shift/saturate).
//   Instantiated once; unit-testable in isolation.
//  Top holds FSM, counters, output register.
// TESTING (bench uses W=2,H=2,C=2, ACT_WIDTH=8 unless noted)
//  1 Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; psum_ready=0.
//  2 Basic: relu=1, shift=0, psums 5,-3,7,0,1,2,3,4 -> out 5,0,7,0,1,2,3,4.
//    Checks: index 0..7; last only on index 7; done pulse one cycle after last handshake.
//  3 Round/sat: shift=4: 24->2, 23->1, -24->-1 (relu=0). shift=0: 300->127, -300->-128.
//  4 Backpressure: ofmap_ready=0 for 5 cycles mid-stream -> psum_ready=0, ofmap_* stable.
//    On release the stream continues with no loss or duplication.
//  5 Control: start pulses during DRAIN/FLUSH ignored. Ninth psum after last not accepted.
//    Second start after done drains again from index 0 with newly latched cfg.
//  6 Reset mid-drain at index 3 -> IDLE, outputs 0. Restart produces the full 8 words,
//    matching the golden file line for line.

Source files
------------

// File: rtl/ofmap_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ofmap_drain_pkg
//  Description : Shared constants and state encoding for the ofmap drain path.
//                Default widths and AlexNet Conv1 ofmap geometry, the drain
//                FSM state encoding, and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ofmap_drain_pkg;

    // Default datapath widths
    localparam int DEF_PSUM_WIDTH = 16;
    localparam int DEF_ACT_WIDTH  = 16;
    localparam int DEF_SHIFT_W    = 5;

    // AlexNet Conv1 output feature map geometry
    localparam int DEF_OFMAP_W    = 55;
    localparam int DEF_OFMAP_H    = 55;
    localparam int DEF_OFMAP_C    = 96;

    // Drain FSM encoding
    typedef logic [1:0] drain_state_t;
    localparam drain_state_t ST_IDLE  = 2'd0;
    localparam drain_state_t ST_DRAIN = 2'd1;
    localparam drain_state_t ST_FLUSH = 2'd2;
    localparam drain_state_t ST_DONE  = 2'd3;

    // Counter width able to hold 0..n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofmap_drain_requant.sv
`default_nettype none
// ============================================================================
//  Module      : ofmap_drain_requant
//  Description : Combinational requantiser for one psum word:
//                optional ReLU, round-half-up arithmetic right shift,
//                signed saturation to the activation width.
//  Ports       : psum    in  signed psum word
//                relu_en in  clamp negative psum to zero before shifting
//                shift   in  right-shift amount
//                act     out saturated, requantised activation
//  Revision    : 1.0 - initial release
// ============================================================================
module ofmap_drain_requant
    import ofmap_drain_pkg::*;
#(
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int ACT_WIDTH  = DEF_ACT_WIDTH,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic signed [PSUM_WIDTH-1:0] psum,
    input  logic                         relu_en,
    input  logic        [SHIFT_W-1:0]    shift,
    output logic signed [ACT_WIDTH-1:0]  act
);

    // Saturation bounds expressed at the widened (PSUM_WIDTH+1) sum width
    localparam int SAT_MAX_I = (1 << (ACT_WIDTH - 1)) - 1;
    localparam int SAT_MIN_I = -(1 << (ACT_WIDTH - 1));
    localparam logic signed [PSUM_WIDTH:0] SAT_MAX = SAT_MAX_I[PSUM_WIDTH:0];
    localparam logic signed [PSUM_WIDTH:0] SAT_MIN = SAT_MIN_I[PSUM_WIDTH:0];

    logic signed [PSUM_WIDTH-1:0] w_x;
    logic        [SHIFT_W-1:0]    w_shift_m1;
    logic        [PSUM_WIDTH:0]   w_round;
    logic signed [PSUM_WIDTH:0]   w_sum;
    logic signed [PSUM_WIDTH:0]   w_y;

    assign w_x        = (relu_en && psum[PSUM_WIDTH-1]) ? '0 : psum;
    assign w_shift_m1 = shift - 1'b1;

    // Half-LSB of the result; zero when no shift is applied
    assign w_round = (shift == '0) ? '0
                   : ({{PSUM_WIDTH{1'b0}}, 1'b1} << w_shift_m1);

    // One extra bit of headroom keeps the rounding add from wrapping
    assign w_sum = {w_x[PSUM_WIDTH-1], w_x} + $signed(w_round);
    assign w_y   = w_sum >>> shift;

    always_comb begin
        act = w_y[ACT_WIDTH-1:0];
        if (w_y > SAT_MAX) begin
            act = SAT_MAX[ACT_WIDTH-1:0];
        end else if (w_y < SAT_MIN) begin
            act = SAT_MIN[ACT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofmap_drain.sv
`default_nettype none
// ============================================================================
//  Module      : ofmap_drain
//  Description : Drains one layer's output feature map from the PE-array psum
//                stream. Each accepted psum is requantised and emitted one
//                cycle later in raster order (col, row, channel) together with
//                its flat index. Single registered output stage with full
//                throughput under continuous ready.
//  Ports       : clk, rst_n            clock / async active-low reset
//                start                 pulse to begin a drain (IDLE only)
//                cfg_relu_en/cfg_shift requant config, latched at start
//                psum_data/valid/ready input stream from the array
//                ofmap_data/valid/ready output activation stream
//                ofmap_index           flat index c*H*W + r*W + col
//                ofmap_last            final word of the map
//                busy                  drain in progress (DRAIN/FLUSH)
//                done                  one-cycle pulse after final handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module ofmap_drain
    import ofmap_drain_pkg::*;
#(
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int ACT_WIDTH  = DEF_ACT_WIDTH,
    parameter int OFMAP_W    = DEF_OFMAP_W,
    parameter int OFMAP_H    = DEF_OFMAP_H,
    parameter int OFMAP_C    = DEF_OFMAP_C,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cfg_relu_en,
    input  logic        [SHIFT_W-1:0]    cfg_shift,
    input  logic signed [PSUM_WIDTH-1:0] psum_data,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    output logic signed [ACT_WIDTH-1:0]  ofmap_data,
    output logic                         ofmap_valid,
    input  logic                         ofmap_ready,
    output logic        [31:0]           ofmap_index,
    output logic                         ofmap_last,
    output logic                         busy,
    output logic                         done
);

    localparam int COL_W = cnt_width(OFMAP_W);
    localparam int ROW_W = cnt_width(OFMAP_H);
    localparam int CH_W  = cnt_width(OFMAP_C);

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(OFMAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(OFMAP_H - 1);
    localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(OFMAP_C - 1);
    localparam logic [31:0]      LAST_IDX = 32'(OFMAP_W * OFMAP_H * OFMAP_C - 1);

    drain_state_t                r_state;
    logic         [COL_W-1:0]    r_col;
    logic         [ROW_W-1:0]    r_row;
    logic         [CH_W-1:0]     r_ch;
    logic         [31:0]         r_idx;
    logic                        r_relu;
    logic         [SHIFT_W-1:0]  r_shift;

    logic                        w_in_xfer;
    logic                        w_out_xfer;
    logic signed [ACT_WIDTH-1:0] w_act;

    // A new psum may enter only when the output register is free or being
    // emptied this same cycle, which gives one word per clock when unstalled.
    assign psum_ready = (r_state == ST_DRAIN) && (!ofmap_valid || ofmap_ready);
    assign w_in_xfer  = psum_valid && psum_ready;
    assign w_out_xfer = ofmap_valid && ofmap_ready;

    assign busy = (r_state == ST_DRAIN) || (r_state == ST_FLUSH);
    assign done = (r_state == ST_DONE);

    ofmap_drain_requant #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .ACT_WIDTH  (ACT_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_requant (
        .psum    (psum_data),
        .relu_en (r_relu),
        .shift   (r_shift),
        .act     (w_act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_ch        <= '0;
            r_idx       <= '0;
            r_relu      <= 1'b0;
            r_shift     <= '0;
            ofmap_data  <= '0;
            ofmap_valid <= 1'b0;
            ofmap_index <= '0;
            ofmap_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_relu  <= cfg_relu_en;
                        r_shift <= cfg_shift;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (w_in_xfer) begin
                        ofmap_data  <= w_act;
                        ofmap_index <= r_idx;
                        ofmap_last  <= (r_idx == LAST_IDX);
                        ofmap_valid <= 1'b1;
                        r_idx       <= r_idx + 32'd1;
                        // Raster walk: column fastest, then row, then channel
                        if (r_col == COL_MAX) begin
                            r_col <= '0;
                            if (r_row == ROW_MAX) begin
                                r_row <= '0;
                                r_ch  <= (r_ch == CH_MAX) ? '0 : r_ch + 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_FLUSH;
                        end
                    end else if (w_out_xfer) begin
                        ofmap_valid <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    // Only the final word is left in the output register
                    if (w_out_xfer) begin
                        ofmap_valid <= 1'b0;
                        ofmap_last  <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_col       <= '0;
                    r_row       <= '0;
                    r_ch        <= '0;
                    r_idx       <= '0;
                    r_relu      <= 1'b0;
                    r_shift     <= '0;
                    ofmap_data  <= '0;
                    ofmap_index <= '0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofmap_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ofmap_drain
//  Description : Directed self-checking bench for ofmap_drain on a 2x2x2 map
//                with 8-bit activations. Expected activations are
//                hand-computed per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofmap_drain;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               cfg_relu_en;
    logic [4:0]         cfg_shift;
    logic signed [15:0] psum_data;
    logic               psum_valid;
    logic               psum_ready;
    logic signed [7:0]  ofmap_data;
    logic               ofmap_valid;
    logic               ofmap_ready;
    logic [31:0]        ofmap_index;
    logic               ofmap_last;
    logic               busy;
    logic               done;

    int tests_run    = 0;
    int tests_failed = 0;

    int g_ps[8];
    int g_ex[8];

    ofmap_drain #(
        .PSUM_WIDTH (16),
        .ACT_WIDTH  (8),
        .OFMAP_W    (2),
        .OFMAP_H    (2),
        .OFMAP_C    (2),
        .SHIFT_W    (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_relu_en (cfg_relu_en),
        .cfg_shift   (cfg_shift),
        .psum_data   (psum_data),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .ofmap_data  (ofmap_data),
        .ofmap_valid (ofmap_valid),
        .ofmap_ready (ofmap_ready),
        .ofmap_index (ofmap_index),
        .ofmap_last  (ofmap_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one full drain of g_ps and checks the output stream against g_ex.
    // stall_at : output index at which ofmap_ready is dropped for 5 cycles (-1 none)
    // ctl      : toggle start / junk cfg during the drain and offer a ninth psum
    // abort_at : output index at which rst_n is asserted mid-cycle (-1 none)
    task automatic run_stream(input string name, input bit relu, input logic [4:0] sh,
                              input int stall_at, input bit ctl, input int abort_at);
        int in_i = 0;
        int out_i = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit stalled = 0;
        bit aborted = 0;
        logic [7:0]  h_data;
        logic [31:0] h_idx;
        logic        h_last;
        logic        exp_ready;
        logic [7:0]  e_data;

        @(negedge clk);
        start = 1'b1; cfg_relu_en = relu; cfg_shift = sh;
        ofmap_ready = 1'b1; psum_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end

        while (out_i < 8 && cyc < 200 && !aborted) begin
            if (abort_at >= 0 && ofmap_valid && ofmap_index == 32'(abort_at)) begin
                #3 rst_n = 1'b0;
                #1;
                tests_run++;
                if ({ofmap_valid, ofmap_data, ofmap_index, ofmap_last, busy, done, psum_ready} !== '0) begin
                    tests_failed++;
                    $display("FAIL %s abort_outputs: got v=%b d=%0d i=%0d l=%b busy=%b done=%b rdy=%b expected all 0",
                             name, ofmap_valid, ofmap_data, ofmap_index, ofmap_last, busy, done, psum_ready);
                end
                psum_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
            end else begin
                if (!stalled && stall_at >= 0 && ofmap_valid && out_i == stall_at) begin
                    stall_cnt = 5; stalled = 1;
                    h_data = ofmap_data; h_idx = ofmap_index; h_last = ofmap_last;
                end
                ofmap_ready = (stall_cnt == 0);
                if (ctl) begin
                    start = cyc[0]; cfg_relu_en = !relu; cfg_shift = 5'd0;
                end
                if (in_i < 8) begin
                    psum_valid = 1'b1; psum_data = 16'(g_ps[in_i]);
                end else begin
                    psum_valid = ctl; psum_data = 16'sd99;
                end
                #4;
                exp_ready = (in_i < 8) && (!ofmap_valid || ofmap_ready);
                tests_run++;
                if (psum_ready !== exp_ready) begin
                    tests_failed++;
                    $display("FAIL %s psum_ready cyc%0d: got %b expected %b", name, cyc, psum_ready, exp_ready);
                end
                tests_run++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s busy_done cyc%0d: got busy=%b done=%b expected 1/0", name, cyc, busy, done);
                end
                if (stall_cnt > 0) begin
                    tests_run++;
                    if (ofmap_valid !== 1'b1 || ofmap_data !== h_data || ofmap_index !== h_idx || ofmap_last !== h_last) begin
                        tests_failed++;
                        $display("FAIL %s stall_hold cyc%0d: got v=%b d=%0d i=%0d l=%b expected 1 %0d %0d %b",
                                 name, cyc, ofmap_valid, ofmap_data, ofmap_index, ofmap_last, h_data, h_idx, h_last);
                    end
                    stall_cnt--;
                end
                if (psum_valid && psum_ready && in_i < 8) in_i++;
                if (ofmap_valid && ofmap_ready) begin
                    e_data = g_ex[out_i][7:0];
                    tests_run++;
                    if (ofmap_data !== e_data || ofmap_index !== 32'(out_i) || ofmap_last !== (out_i == 7)) begin
                        tests_failed++;
                        $display("FAIL %s word%0d: got d=%0d i=%0d l=%b expected d=%0d i=%0d l=%b",
                                 name, out_i, ofmap_data, ofmap_index, ofmap_last,
                                 $signed(e_data), out_i, (out_i == 7));
                    end
                    out_i++;
                end
                @(negedge clk);
                cyc++;
            end
        end

        start = 1'b0; psum_valid = 1'b0; ofmap_ready = 1'b1;
        if (!aborted) begin
            tests_run++;
            if (cyc >= 200) begin
                tests_failed++;
                $display("FAIL %s timeout: got %0d words expected 8", name, out_i);
            end
            #4;
            tests_run++;
            if (done !== 1'b1 || busy !== 1'b0 || ofmap_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s done_pulse: got done=%b busy=%b v=%b expected 1/0/0", name, done, busy, ofmap_valid);
            end
            @(negedge clk);
            #4;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || psum_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s done_clear: got done=%b busy=%b rdy=%b expected 0/0/0", name, done, busy, psum_ready);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ofmap_valid, ofmap_data, ofmap_index, ofmap_last, busy, done, psum_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: got v=%b d=%0d i=%0d l=%b busy=%b done=%b rdy=%b expected all 0",
                     ofmap_valid, ofmap_data, ofmap_index, ofmap_last, busy, done, psum_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || psum_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b rdy=%b expected 0/0", busy, psum_ready);
        end
    endtask

    task automatic test_basic();
        g_ps = '{5, -3, 7, 0, 1, 2, 3, 4};
        g_ex = '{5, 0, 7, 0, 1, 2, 3, 4};
        run_stream("basic", 1'b1, 5'd0, -1, 1'b0, -1);
    endtask

    task automatic test_round_sat();
        g_ps = '{24, 23, -24, 8, -8, 40, 32767, -32768};
        g_ex = '{2, 1, -1, 1, 0, 3, 127, -128};
        run_stream("round_s4", 1'b0, 5'd4, -1, 1'b0, -1);
        g_ps = '{300, -300, 127, 128, -128, -129, 1, -1};
        g_ex = '{127, -128, 127, 127, -128, -128, 1, -1};
        run_stream("sat_s0", 1'b0, 5'd0, -1, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        g_ps = '{10, -20, 30, -40, 50, -60, 70, -80};
        g_ex = '{10, -20, 30, -40, 50, -60, 70, -80};
        run_stream("backpressure", 1'b0, 5'd0, 3, 1'b0, -1);
    endtask

    task automatic test_control();
        g_ps = '{4, 5, 6, -7, 10, 2, 1, -1};
        g_ex = '{1, 1, 2, 0, 3, 1, 0, 0};
        run_stream("ctl_ignore", 1'b1, 5'd2, -1, 1'b1, -1);
        g_ps = '{-5, 5, 3, -3, 1, -1, 2, 0};
        g_ex = '{-2, 3, 2, -1, 1, 0, 1, 0};
        run_stream("ctl_restart", 1'b0, 5'd1, -1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_drain();
        g_ps = '{100, 200, -50, 60, -70, 80, -90, 110};
        g_ex = '{100, 127, -50, 60, -70, 80, -90, 110};
        run_stream("abort", 1'b0, 5'd0, -1, 1'b0, 3);
        run_stream("after_abort", 1'b0, 5'd0, -1, 1'b0, -1);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; cfg_relu_en = 1'b0; cfg_shift = 5'd0;
        psum_data = '0; psum_valid = 1'b0; ofmap_ready = 1'b1;
        test_reset();
        test_basic();
        test_round_sat();
        test_backpressure();
        test_control();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
